// File: rtl/axis_stream_checker.sv
// -----------------------------------------------------------------------------
// axis_stream_checker
//
// AXI-Stream sink that consumes LENGTH words, applies a repeating ready
// (backpressure) pattern and compares every accepted word against a locally
// regenerated Galois-LFSR sequence starting at SEED.
//
// When the run finishes, either because all words were received or because the
// source went idle for too long, the block reports the outcome (done, pass,
// timed_out) and the error statistics.
//
// Ports
//   clk             in   clock, all logic on posedge
//   rst             in   asynchronous reset, active-high
//   s_axis_valid    in   upstream data valid
//   s_axis_data     in   upstream data [D_W]
//   s_axis_ready    out  sink ready (combinational from registered state)
//   done            out  run finished (all words received or timeout)
//   pass            out  done with zero mismatches and no timeout
//   timed_out       out  done caused by timeout
//   rx_count        out  words accepted so far [CW]
//   err_count       out  mismatching words so far [CW]
//   first_err_idx   out  0-based index of the first mismatching word [CW]
//   first_err_data  out  data received at the first mismatch [D_W]
// -----------------------------------------------------------------------------
module axis_stream_checker #(
    parameter int              D_W       = 32,
    parameter logic [D_W-1:0]  SEED      = D_W'(725),
    parameter int              LENGTH    = 8,
    parameter logic [D_W-1:0]  TAPS      = D_W'(32'h8020_0003),
    parameter logic [7:0]      READY_PAT = 8'b1110_0110,
    parameter int              TIMEOUT   = 64,
    localparam int             CW        = $clog2(LENGTH + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           s_axis_valid,
    input  logic [D_W-1:0] s_axis_data,
    output logic           s_axis_ready,
    output logic           done,
    output logic           pass,
    output logic           timed_out,
    output logic [CW-1:0]  rx_count,
    output logic [CW-1:0]  err_count,
    output logic [CW-1:0]  first_err_idx,
    output logic [D_W-1:0] first_err_data
);

    // The idle counter never needs to hold more than TIMEOUT-1.
    localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit TO_EN = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DONE,
        ST_TOUT
    } state_t;

    state_t         state_q,          state_d;
    logic [D_W-1:0] expected_q,       expected_d;
    logic [2:0]     pat_idx_q,        pat_idx_d;
    logic [TW-1:0]  idle_cnt_q,       idle_cnt_d;
    logic [CW-1:0]  rx_count_q,       rx_count_d;
    logic [CW-1:0]  err_count_q,      err_count_d;
    logic [CW-1:0]  first_err_idx_q,  first_err_idx_d;
    logic [D_W-1:0] first_err_data_q, first_err_data_d;
    logic           done_q,           done_d;
    logic           pass_q,           pass_d;
    logic           timed_out_q,      timed_out_d;

    logic           accept;
    logic           mismatch;
    logic           timeout_hit;
    logic [D_W-1:0] lfsr_next;

    // Ready depends only on registered state, never on valid.
    assign s_axis_ready = (state_q == ST_RUN) & READY_PAT[pat_idx_q];
    assign accept       = s_axis_valid & s_axis_ready;
    assign mismatch     = accept & (s_axis_data != expected_q);
    assign lfsr_next    = (expected_q >> 1) ^ (expected_q[0] ? TAPS : '0);

    // An idle cycle that would make the idle count reach TIMEOUT ends the run.
    assign timeout_hit  = TO_EN && (state_q == ST_RUN) && !s_axis_valid &&
                          (idle_cnt_q == TW'(TIMEOUT - 1));

    always_comb begin
        state_d          = state_q;
        expected_d       = expected_q;
        pat_idx_d        = pat_idx_q;
        idle_cnt_d       = idle_cnt_q;
        rx_count_d       = rx_count_q;
        err_count_d      = err_count_q;
        first_err_idx_d  = first_err_idx_q;
        first_err_data_d = first_err_data_q;
        done_d           = done_q;
        pass_d           = pass_q;
        timed_out_d      = timed_out_q;

        if (state_q == ST_RUN) begin
            pat_idx_d  = pat_idx_q + 3'd1;
            idle_cnt_d = s_axis_valid ? '0 : idle_cnt_q + TW'(1);

            if (accept) begin
                rx_count_d = rx_count_q + CW'(1);
                expected_d = lfsr_next;
                if (mismatch) begin
                    err_count_d = err_count_q + CW'(1);
                    if (err_count_q == '0) begin
                        first_err_idx_d  = rx_count_q;
                        first_err_data_d = s_axis_data;
                    end
                end
                if (rx_count_q == CW'(LENGTH - 1)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    // Includes the verdict on the word being accepted now.
                    pass_d  = (err_count_d == '0);
                end
            end else if (timeout_hit) begin
                // valid=0 here, so this can never coincide with the final accept.
                state_d     = ST_TOUT;
                done_d      = 1'b1;
                timed_out_d = 1'b1;
                pass_d      = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= ST_RUN;
            expected_q       <= SEED;
            pat_idx_q        <= '0;
            idle_cnt_q       <= '0;
            rx_count_q       <= '0;
            err_count_q      <= '0;
            first_err_idx_q  <= '0;
            first_err_data_q <= '0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
            timed_out_q      <= 1'b0;
        end else begin
            state_q          <= state_d;
            expected_q       <= expected_d;
            pat_idx_q        <= pat_idx_d;
            idle_cnt_q       <= idle_cnt_d;
            rx_count_q       <= rx_count_d;
            err_count_q      <= err_count_d;
            first_err_idx_q  <= first_err_idx_d;
            first_err_data_q <= first_err_data_d;
            done_q           <= done_d;
            pass_q           <= pass_d;
            timed_out_q      <= timed_out_d;
        end
    end

    assign done           = done_q;
    assign pass           = pass_q;
    assign timed_out      = timed_out_q;
    assign rx_count       = rx_count_q;
    assign err_count      = err_count_q;
    assign first_err_idx  = first_err_idx_q;
    assign first_err_data = first_err_data_q;

endmodule
